// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and state encoding for the FIFO write arbiter.
//   N_REQ       : number of producers competing for the FIFO
//   DATA_W      : width of one producer byte / FIFO entry
//   FIFO_USABLE : occupancy at which no further writes are issued
package fifo_wr_arbiter_pkg;

    localparam int N_REQ       = 4;
    localparam int DATA_W      = 8;
    localparam int FIFO_USABLE = 7;

    typedef enum logic {
        ARB   = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick4.sv
// Combinational round-robin pick over four requesters.
//   req   : request vector
//   last  : index of the previous winner; search starts at last+1
//   valid : at least one requester is active
//   idx   : winning requester index
module rr_pick4
    import fifo_wr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last,
    output logic             valid,
    output logic [1:0]       idx
);

    logic       found;
    logic [1:0] cand;

    // Offsets 1..4 wrap modulo 4, so the previous winner is checked last.
    always_comb begin
        found = 1'b0;
        idx   = 2'd0;
        cand  = 2'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last + k[1:0];
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a shared 8-entry FIFO.
// Four producers hold req with their byte until acked; one byte is
// written every two cycles at most (ARB cycle, then WRITE cycle).
// Occupancy is tracked locally and writes stop at 7 entries.
//   clk, clrn  : clock, async active-low reset
//   req        : per-producer request
//   req_data   : producer bytes, producer i on [8i+7:8i]
//   ack        : one-hot pulse, byte of that producer accepted
//   fifo_write : write strobe to the FIFO
//   fifo_data  : byte written to the FIFO
//   fifo_read  : consumer read strobe seen by the FIFO
//   fifo_ready : FIFO not-empty flag
//   count      : tracked occupancy 0..7
//   full       : count == 7
//   grant_id   : last granted producer
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
(
    input  logic                      clk,
    input  logic                      clrn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      fifo_write,
    output logic [DATA_W-1:0]         fifo_data,
    input  logic                      fifo_read,
    input  logic                      fifo_ready,
    output logic [2:0]                count,
    output logic                      full,
    output logic [1:0]                grant_id
);

    state_t              state, state_nx;
    logic                win_valid;
    logic [1:0]          win_idx;
    logic [DATA_W-1:0]   win_byte;
    logic                go;
    logic                rd;

    rr_pick4 u_pick (
        .req   (req),
        .last  (grant_id),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == 2'(i)) win_byte = req_data[i*DATA_W +: DATA_W];
        end
    end

    // A grant is only possible from ARB, so WRITE never re-arbitrates.
    assign go = (state == ARB) && win_valid && (count < 3'(FIFO_USABLE));
    assign rd = fifo_read & fifo_ready;

    always_comb begin
        state_nx = state;
        case (state)
            ARB:     if (go) state_nx = WRITE;
            WRITE:   state_nx = ARB;
            default: state_nx = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= ARB;
        else       state <= state_nx;
    end

    // Outputs are registered on the ARB->WRITE edge and dropped on the
    // following edge, giving the single-cycle write/ack pulse.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fifo_write <= 1'b0;
            fifo_data  <= '0;
            ack        <= '0;
            grant_id   <= 2'd3;
        end else begin
            fifo_write <= go;
            ack        <= go ? (N_REQ'(1) << win_idx) : '0;
            if (go) begin
                grant_id  <= win_idx;
                fifo_data <= win_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count <= 3'd0;
        end else begin
            case ({fifo_write, rd})
                2'b10:   if (count != 3'd7) count <= count + 3'd1;
                2'b01:   if (count != 3'd0) count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign full = (count == 3'(FIFO_USABLE));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        fifo_read = 1'b0;
    logic        fifo_ready = 1'b0;
    logic [3:0]  ack;
    logic        fifo_write;
    logic [7:0]  fifo_data;
    logic [2:0]  count;
    logic        full;
    logic [1:0]  grant_id;

    fifo_wr_arbiter dut (
        .clk        (clk),
        .clrn       (clrn),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .fifo_write (fifo_write),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .fifo_ready (fifo_ready),
        .count      (count),
        .full       (full),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Behavioural model: a write cycle follows every grant; grants only in
    // cycles that are not write cycles, with occupancy below 7.
    logic        m_write = 1'b0;
    logic [3:0]  m_ack = '0;
    logic [7:0]  m_data = '0;
    int          m_gid = 3;
    int          m_count = 0;
    int          m_nc;
    int          m_w;
    logic        m_rd;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_write = 1'b0; m_ack = '0; m_data = '0; m_gid = 3; m_count = 0;
        end else begin
            m_rd = fifo_read && fifo_ready;
            m_nc = m_count;
            if (m_write && !m_rd)      m_nc = (m_nc < 7) ? m_nc + 1 : 7;
            else if (!m_write && m_rd) m_nc = (m_nc > 0) ? m_nc - 1 : 0;
            m_w = -1;
            if (!m_write && req != 0 && m_count < 7) begin
                for (int k = 1; k <= 4; k++)
                    if (m_w < 0 && req[(m_gid + k) % 4]) m_w = (m_gid + k) % 4;
            end
            if (m_w >= 0) begin
                m_write = 1'b1;
                m_ack   = 4'(1 << m_w);
                m_data  = req_data[8*m_w +: 8];
                m_gid   = m_w;
            end else begin
                m_write = 1'b0;
                m_ack   = '0;
            end
            m_count = m_nc;
        end
    end

    always @(negedge clk) begin
        chk("cycle_outputs {full,count,gid,data,ack,wr}",
            32'({full, count, grant_id, fifo_data, ack, fifo_write}),
            32'({(m_count == 7), 3'(m_count), 2'(m_gid), m_data, m_ack, m_write}));
    end

    // Environment: the FIFO itself plus a log of accepted writes.
    logic [7:0] fq[$];
    logic [7:0] wlog[$];
    int         wcyc[$];
    int         cyc = 0;
    int         ackn = 0;
    logic       ovf = 1'b0;
    logic [7:0] last_pop = '0;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fq.delete();
        end else begin
            cyc++;
            if (fifo_read && fifo_ready && fq.size() > 0) last_pop = fq.pop_front();
            if (fifo_write) begin
                fq.push_back(fifo_data);
                wlog.push_back(fifo_data);
                wcyc.push_back(cyc);
                if (fq.size() > 7) ovf = 1'b1;
            end
            if (ack != 0) ackn++;
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        clrn = 1'b0; req = '0; fifo_read = 1'b0; fifo_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 clrn = 1'b1;
        wlog.delete(); wcyc.delete(); ackn = 0; ovf = 1'b0;
    endtask

    task automatic wait_ack(input int maxc);
        int n = 0;
        while (ack == 0 && n < maxc) begin tick(); n++; end
        chk("ack_seen", 32'(ack != 0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        do_reset();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_write", 32'(fifo_write), 32'h0);
        chk("rst_data", 32'(fifo_data), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h3);

        // single requester
        req = 4'b0001; req_data = 32'h0000_00A5;
        tick();
        chk("s1_write", 32'(fifo_write), 32'h1);
        chk("s1_data", 32'(fifo_data), 32'hA5);
        chk("s1_ack", 32'(ack), 32'h1);
        chk("s1_gid", 32'(grant_id), 32'h0);
        req = '0;
        tick();
        chk("s1_count", 32'(count), 32'h1);
        chk("s1_write_off", 32'(fifo_write), 32'h0);

        // round robin, all requesting
        do_reset();
        req = 4'hF; req_data = 32'h1312_1110;
        repeat (10) tick();
        req = '0;
        chk("rr_nwrites", 32'(wlog.size()), 32'd5);
        if (wlog.size() == 5) begin
            chk("rr_w0", 32'(wlog[0]), 32'h10);
            chk("rr_w1", 32'(wlog[1]), 32'h11);
            chk("rr_w2", 32'(wlog[2]), 32'h12);
            chk("rr_w3", 32'(wlog[3]), 32'h13);
            chk("rr_w4", 32'(wlog[4]), 32'h10);
            for (int i = 0; i < 4; i++)
                chk("rr_spacing", 32'(wcyc[i+1] - wcyc[i]), 32'd2);
        end
        chk("rr_count", 32'(count), 32'd5);

        // fill to 7 with no reads
        do_reset();
        req = 4'b0100; req_data = 32'h0077_0000;
        repeat (20) tick();
        chk("full_acks", 32'(ackn), 32'd7);
        chk("full_count", 32'(count), 32'd7);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_writes", 32'(wlog.size()), 32'd7);
        chk("full_no_write", 32'(fifo_write), 32'd0);
        chk("full_ovf", 32'(ovf), 32'd0);

        // drain one from full, producer still requesting
        fifo_read = 1'b1; fifo_ready = 1'b1;
        tick();
        fifo_read = 1'b0; fifo_ready = 1'b0;
        chk("drain_count", 32'(count), 32'd6);
        chk("drain_full", 32'(full), 32'd0);
        chk("drain_pop", 32'(last_pop), 32'h77);
        tick();
        chk("drain_write", 32'(fifo_write), 32'd1);
        chk("drain_ack", 32'(ack), 32'h4);
        req = '0;
        tick();
        chk("drain_refill", 32'(count), 32'd7);
        chk("drain_refull", 32'(full), 32'd1);
        chk("drain_ovf", 32'(ovf), 32'd0);

        // simultaneous read and write at count 3
        do_reset();
        req = 4'b0001;
        for (int b = 8'h31; b <= 8'h33; b++) begin
            req_data = 32'(b);
            wait_ack(4);
            chk("rw_data", 32'(fifo_data), 32'(b));
            tick();
        end
        chk("rw_count3", 32'(count), 32'd3);
        req_data = 32'h34;
        tick();
        chk("rw_write", 32'(fifo_write), 32'd1);
        req = '0;
        fifo_read = 1'b1; fifo_ready = 1'b1;
        tick();
        fifo_read = 1'b0; fifo_ready = 1'b0;
        chk("rw_count_same", 32'(count), 32'd3);
        chk("rw_pop_first", 32'(last_pop), 32'h31);
        chk("rw_order", 32'({wlog.size() == 4 ? {wlog[0], wlog[1], wlog[2], wlog[3]} : 32'h0}),
            32'h3132_3334);

        // reset during the write cycle
        do_reset();
        req = 4'b0010; req_data = 32'h0000_5A00;
        tick();
        chk("rw_pre_write", 32'(fifo_write), 32'd1);
        #1 clrn = 1'b0;
        #1;
        chk("rstw_write", 32'(fifo_write), 32'd0);
        chk("rstw_ack", 32'(ack), 32'd0);
        chk("rstw_count", 32'(count), 32'd0);
        chk("rstw_gid", 32'(grant_id), 32'd3);
        @(posedge clk); #2 clrn = 1'b1;
        tick();
        chk("rstw_regrant_write", 32'(fifo_write), 32'd1);
        chk("rstw_regrant_ack", 32'(ack), 32'h2);
        chk("rstw_regrant_gid", 32'(grant_id), 32'd1);
        chk("rstw_regrant_data", 32'(fifo_data), 32'h5A);
        req = '0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
